// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the display scheduler: FSM states and display codes.
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    S_TRAFFIC = 2'd0,
    S_ROLL    = 2'd1,
    S_SHOW    = 2'd2
  } state_e;

  localparam logic [2:0] DISP_ERR = 3'b111;

  function automatic logic dice_invalid(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b111);
  endfunction

endpackage

// File: rtl/display_scheduler_tick_divider.sv
// Free-running prescaler that emits a registered one-cycle tick per DIV enabled cycles.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));

  // Count is held, not cleared, while en is low so the phase survives pauses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= en && wrap;
      if (en) cnt_q <= wrap ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/display_scheduler.sv
// Shares the 3-bit result display between traffic lights (default) and the dice (roll + timed hold).
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned TL_DIV      = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned MIN_ROLL    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] dice_value,
  input  logic [2:0] lights,
  output logic       dice_roll,
  output logic       tl_tick,
  output logic       sel,
  output logic [2:0] result
);

  localparam int unsigned RW = $clog2(MIN_ROLL + 1);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e        state_q;
  logic          button_q;
  logic          sel_q, dice_roll_q;
  logic [RW-1:0] roll_cnt_q, roll_cnt_d;
  logic [HW-1:0] hold_cnt_q;
  logic [2:0]    result_q, result_d;
  logic          press, roll_done, hold_last, div_en;

  assign press = button & ~button_q;

  // Incremented count includes the current cycle, so a tap rolls exactly MIN_ROLL cycles.
  assign roll_cnt_d = (roll_cnt_q == RW'(MIN_ROLL)) ? roll_cnt_q : roll_cnt_q + RW'(1);
  assign roll_done  = (roll_cnt_d >= RW'(MIN_ROLL));
  assign hold_last  = (hold_cnt_q == HW'(HOLD_CYCLES - 1));

  // Freeze on the press edge too, so no tick can coincide with sel rising.
  assign div_en = (state_q == S_TRAFFIC) && !press;

  tick_divider #(.DIV(TL_DIV)) u_tl_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .tick (tl_tick)
  );

  always_comb begin
    result_d = lights;
    if (sel_q) begin
      result_d = dice_value;
      if (state_q == S_SHOW && dice_invalid(dice_value)) result_d = DISP_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_TRAFFIC;
      button_q    <= 1'b0;
      sel_q       <= 1'b0;
      dice_roll_q <= 1'b0;
      roll_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      result_q    <= '0;
    end else begin
      button_q <= button;
      result_q <= result_d;
      case (state_q)
        S_TRAFFIC: begin
          if (press) begin
            state_q     <= S_ROLL;
            sel_q       <= 1'b1;
            dice_roll_q <= 1'b1;
            roll_cnt_q  <= '0;
            hold_cnt_q  <= '0;
          end
        end
        S_ROLL: begin
          roll_cnt_q <= roll_cnt_d;
          if (!button && roll_done) begin
            state_q     <= S_SHOW;
            dice_roll_q <= 1'b0;
            hold_cnt_q  <= '0;
          end
        end
        S_SHOW: begin
          if (press) begin
            state_q     <= S_ROLL;
            dice_roll_q <= 1'b1;
            roll_cnt_q  <= '0;
            hold_cnt_q  <= '0;
          end else if (hold_last) begin
            state_q    <= S_TRAFFIC;
            sel_q      <= 1'b0;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        default: begin
          state_q     <= S_TRAFFIC;
          sel_q       <= 1'b0;
          dice_roll_q <= 1'b0;
          roll_cnt_q  <= '0;
          hold_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign dice_roll = dice_roll_q;
  assign result    = result_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Randomised and directed bench for display_scheduler against a cycle-level behavioural model.
module tb_display_scheduler;

  localparam int TL_DIV      = 4;
  localparam int HOLD_CYCLES = 8;
  localparam int MIN_ROLL    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] dice_value;
  logic [2:0] lights;
  logic       dice_roll, tl_tick, sel;
  logic [2:0] result;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0=lights, 1=rolling, 2=showing dice.
  int m_mode, m_phase, m_rolled, m_held, m_result;
  bit m_btn, m_sel, m_roll, m_tick;

  display_scheduler #(
    .TL_DIV      (TL_DIV),
    .HOLD_CYCLES (HOLD_CYCLES),
    .MIN_ROLL    (MIN_ROLL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .dice_value (dice_value),
    .lights     (lights),
    .dice_roll  (dice_roll),
    .tl_tick    (tl_tick),
    .sel        (sel),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit press;
    int shown;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_rolled = 0; m_held = 0;
      m_btn = 0; m_tick = 0; m_result = 0;
    end else begin
      press = button && !m_btn;
      m_btn = button;
      if (!m_sel) shown = lights;
      else if (m_mode == 2 && (dice_value == 3'd0 || dice_value == 3'd7)) shown = 7;
      else shown = dice_value;
      m_tick = 0;
      case (m_mode)
        0: if (press) begin
             m_mode = 1; m_rolled = 0;
           end else begin
             m_tick  = (m_phase == TL_DIV - 1);
             m_phase = (m_phase + 1) % TL_DIV;
           end
        1: begin
             m_rolled++;
             if (!button && m_rolled >= MIN_ROLL) begin
               m_mode = 2; m_held = 0;
             end
           end
        default: if (press) begin
             m_mode = 1; m_rolled = 0;
           end else if (m_held == HOLD_CYCLES - 1) begin
             m_mode = 0;
           end else begin
             m_held++;
           end
      endcase
      m_result = shown;
    end
    m_sel  = (m_mode != 0);
    m_roll = (m_mode == 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sel", sel, m_sel);
    chk("dice_roll", dice_roll, m_roll);
    chk("tl_tick", tl_tick, m_tick);
    chk("result", result, m_result);
    chk("tick_vs_sel", tl_tick & sel, 0);
    chk("tick_vs_roll", tl_tick & dice_roll, 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt_roll, cnt_show, cnt_tick, last_tick, found;
    rst = 1'b1; button = 1'b0; dice_value = 3'd3; lights = 3'b100;
    m_sel = 0; m_roll = 0;

    // Reset and release
    steps(2);
    chk("rst_result", result, 0);
    chk("rst_sel", sel, 0);
    chk("rst_roll", dice_roll, 0);
    rst = 1'b0;
    step();
    chk("release_result", result, 3'b100);

    // Idle ticks: exactly 3 in 12 cycles, 4 apart
    cnt_tick = 0; cnt_roll = 0; last_tick = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tl_tick) begin
        if (last_tick >= 0) chk("tick_gap", i - last_tick, TL_DIV);
        last_tick = i;
        cnt_tick++;
      end
      if (dice_roll) cnt_roll++;
    end
    chk("idle_ticks", cnt_tick, 3);
    chk("idle_roll", cnt_roll, 0);

    // Tap: one-cycle press rolls MIN_ROLL cycles then shows HOLD_CYCLES cycles
    dice_value = 3'd5;
    button = 1'b1; step(); button = 1'b0;
    cnt_roll = dice_roll; cnt_show = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (dice_roll) cnt_roll++;
      if (sel && !dice_roll) cnt_show++;
      if (sel && !dice_roll && cnt_show == 2) chk("tap_result", result, 5);
    end
    chk("tap_roll_len", cnt_roll, MIN_ROLL);
    chk("tap_show_len", cnt_show, HOLD_CYCLES);
    steps(6);

    // Long hold: 20 cycles of button keep rolling, SHOW right after release
    button = 1'b1; cnt_roll = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dice_roll) cnt_roll++;
    end
    button = 1'b0;
    chk("hold_roll_len", cnt_roll, 20);
    step();
    chk("hold_show_sel", sel, 1);
    chk("hold_show_roll", dice_roll, 0);
    steps(HOLD_CYCLES + 2);

    // Reroll on the final SHOW cycle
    button = 1'b1; step(); button = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_mode == 2 && m_held == HOLD_CYCLES - 1) found = 1;
      else step();
    end
    chk("reroll_reached", found, 1);
    button = 1'b1; step(); button = 1'b0;
    chk("reroll_sel", sel, 1);
    chk("reroll_roll", dice_roll, 1);
    cnt_show = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sel && !dice_roll) cnt_show++;
    end
    chk("reroll_show_len", cnt_show, HOLD_CYCLES);

    // Reset while rolling
    button = 1'b1; steps(2);
    chk("mid_roll", dice_roll, 1);
    rst = 1'b1; step();
    chk("midrst_sel", sel, 0);
    chk("midrst_roll", dice_roll, 0);
    chk("midrst_tick", tl_tick, 0);
    chk("midrst_result", result, 0);
    rst = 1'b0; button = 1'b0; step();

    // Invalid dice value in SHOW shows the error pattern
    dice_value = 3'd0;
    button = 1'b1; step(); button = 1'b0;
    steps(MIN_ROLL + 1);
    chk("bad_dice_result", result, 7);
    steps(HOLD_CYCLES + 2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) button = ~button;
      dice_value = 3'($urandom_range(0, 7));
      lights     = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
